// File: rtl/apb_master_pkg.sv
// apb_master shared types: FSM state, response error bits,
// and the strobe-width helper.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } apb_mst_state_e;

  localparam int RSP_ERR_SLV = 0;
  localparam int RSP_ERR_TMO = 1;

  function automatic int strb_w(input int dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/apb_master_if.sv
// Command, response and APB bus bundle for apb_master.
// master = requester side, slave = initiator/memory side.
interface apb_master_if
  import apb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) ();
  localparam int STRB_W = strb_w(DATA_W);

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic [STRB_W-1:0] cmd_strb;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic [1:0]        rsp_err;

  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [STRB_W-1:0] pstrb;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr,
    input  cmd_wdata, cmd_strb, rsp_ready,
    input  prdata, pready, pslverr,
    output cmd_ready, rsp_valid, rsp_rdata,
    output rsp_err, psel, penable, pwrite,
    output paddr, pwdata, pstrb
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr,
    output cmd_wdata, cmd_strb, rsp_ready,
    output prdata, pready, pslverr,
    input  cmd_ready, rsp_valid, rsp_rdata,
    input  rsp_err, psel, penable, pwrite,
    input  paddr, pwdata, pstrb
  );
endinterface

// File: rtl/apb_master_wdog.sv
// Wait-state watchdog: counts ACCESS cycles with pready low,
// flags expiry on the last allowed wait cycle.
module apb_wdog #(
  parameter int TIMEOUT_CYC = 256
) (
  input  logic pclk,
  input  logic presetn,
  input  logic clr,
  input  logic tick,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] LIM = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (tick && cnt != LIM) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = (cnt == LIM);
endmodule

// File: rtl/apb_master.sv
// APB4 requester: one command in, one APB transfer out,
// one response back; watchdog aborts stalled slaves.
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 64,
  parameter int TIMEOUT_CYC = 256
) (
  input logic          pclk,
  input logic          presetn,
  apb_master_if.master bus
);
  localparam int STRB_W = strb_w(DATA_W);

  apb_mst_state_e state_q, state_d;

  logic              psel_q, pen_q, pwrite_q;
  logic [ADDR_W-1:0] paddr_q;
  logic [DATA_W-1:0] pwdata_q;
  logic [STRB_W-1:0] pstrb_q;
  logic              rvalid_q;
  logic [DATA_W-1:0] rdata_q;
  logic [1:0]        rerr_q;

  logic       accept, tick, expired;
  logic [1:0] slv_err, tmo_err;

  assign accept = (state_q == IDLE) && bus.cmd_valid;
  assign tick   = (state_q == ACCESS) && !bus.pready;

  apb_wdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_wdog (
    .pclk   (pclk),
    .presetn(presetn),
    .clr    (accept),
    .tick   (tick),
    .expired(expired)
  );

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    slv_err = '0;
    tmo_err = '0;
    slv_err[RSP_ERR_SLV] = bus.pslverr;
    tmo_err[RSP_ERR_TMO] = 1'b1;
    unique case (state_q)
      IDLE:   if (bus.cmd_valid) state_d = SETUP;
      SETUP:  state_d = ACCESS;
      // pready wins over a same-cycle expiry
      ACCESS: if (bus.pready || expired) state_d = RESP;
      RESP:   if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      psel_q   <= 1'b0;
      pen_q    <= 1'b0;
      pwrite_q <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      pstrb_q  <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rerr_q   <= '0;
    end else begin
      psel_q   <= (state_d == SETUP) || (state_d == ACCESS);
      pen_q    <= (state_d == ACCESS);
      rvalid_q <= (state_d == RESP);
      if (accept) begin
        pwrite_q <= bus.cmd_write;
        paddr_q  <= bus.cmd_addr;
        pwdata_q <= bus.cmd_wdata;
        pstrb_q  <= bus.cmd_write ? bus.cmd_strb : '0;
      end
      if (state_q == ACCESS) begin
        if (bus.pready) begin
          rdata_q <= pwrite_q ? '0 : bus.prdata;
          rerr_q  <= slv_err;
        end else if (expired) begin
          rdata_q <= '0;
          rerr_q  <= tmo_err;
        end
      end
    end
  end

  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.psel      = psel_q;
  assign bus.penable   = pen_q;
  assign bus.pwrite    = pwrite_q;
  assign bus.paddr     = paddr_q;
  assign bus.pwdata    = pwdata_q;
  assign bus.pstrb     = pstrb_q;
  assign bus.rsp_valid = rvalid_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = rerr_q;
endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master with a scripted APB slave,
// TIMEOUT_CYC=4 so the watchdog boundary is reachable.
module tb_apb_master;
  import apb_pkg::*;

  localparam int AW  = 32;
  localparam int DW  = 64;
  localparam int TMO = 4;

  logic pclk = 1'b0;
  logic presetn = 1'b0;

  apb_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  apb_master #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .pclk(pclk),
    .presetn(presetn),
    .bus(bus)
  );

  always #5 pclk = ~pclk;

  int npass = 0;
  int ntot = 0;
  logic ps[32];
  logic pe[32];
  logic [7:0] strb_or;
  int lat;
  logic bad;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic issue(input logic w, input logic [31:0] a,
                       input logic [63:0] d, input logic [7:0] s);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    bus.cmd_strb  = s;
    step();
    bus.cmd_valid = 1'b0;
  endtask

  // Called in cycle T+1; returns the cycle index of rsp_valid.
  task automatic run_wait(input int rdy_at, input logic [31:0] emask,
                          output int n);
    n = 1;
    strb_or = '0;
    while (!bus.rsp_valid && n < 30) begin
      ps[n] = bus.psel;
      pe[n] = bus.penable;
      if (bus.psel) strb_or |= bus.pstrb;
      bus.pready  = (n >= rdy_at);
      bus.pslverr = emask[n];
      step();
      n++;
    end
    bus.pready  = 1'b0;
    bus.pslverr = 1'b0;
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.cmd_strb  = '0;
    bus.rsp_ready = 1'b1;
    bus.prdata    = '0;
    bus.pready    = 1'b0;
    bus.pslverr   = 1'b0;

    #1;
    chk("rst_psel", bus.psel, 0);
    chk("rst_penable", bus.penable, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_err", bus.rsp_err, 0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 0);
    chk("rst_paddr", bus.paddr, 0);
    chk("rst_pstrb", bus.pstrb, 0);
    step();
    step();
    presetn = 1'b1;
    step();
    chk("rst_cmd_ready", bus.cmd_ready, 1);

    // zero-wait write
    issue(1'b1, 32'h10, 64'hDEAD_BEEF_0123_4567, 8'hFF);
    chk("wr_cmd_ready", bus.cmd_ready, 0);
    chk("wr_paddr", bus.paddr, 64'h10);
    chk("wr_pwdata", bus.pwdata, 64'hDEAD_BEEF_0123_4567);
    chk("wr_pstrb", bus.pstrb, 64'hFF);
    chk("wr_pwrite", bus.pwrite, 1);
    run_wait(2, 32'h0, lat);
    chk("wr_lat", 64'(lat), 3);
    chk("wr_psel_t1", ps[1], 1);
    chk("wr_pen_t1", pe[1], 0);
    chk("wr_pen_t2", pe[2], 1);
    chk("wr_err", bus.rsp_err, 0);
    chk("wr_rdata", bus.rsp_rdata, 0);
    chk("wr_psel_resp", bus.psel, 0);
    step();

    // read, 3 wait states, pslverr pulses during waits only
    bus.prdata = 64'h1122_3344_5566_7788;
    issue(1'b0, 32'h08, 64'hAAAA_AAAA_AAAA_AAAA, 8'hFF);
    run_wait(5, 32'b0_1100, lat);
    chk("rd_lat", 64'(lat), 6);
    chk("rd_rdata", bus.rsp_rdata, 64'h1122_3344_5566_7788);
    chk("rd_err", bus.rsp_err, 0);
    chk("rd_pstrb", strb_or, 0);
    chk("rd_pen_wait", pe[4], 1);
    step();

    // slave error at completion
    issue(1'b0, 32'h0001_0000, 64'h0, 8'h0F);
    run_wait(3, 32'b1110, lat);
    chk("se_lat", 64'(lat), 4);
    chk("se_err", bus.rsp_err, 2'b01);
    chk("se_rdata", bus.rsp_rdata, 64'h1122_3344_5566_7788);
    step();

    // timeout abort
    issue(1'b0, 32'h20, 64'h0, 8'h00);
    run_wait(99, 32'h0, lat);
    chk("to_lat", 64'(lat), 6);
    chk("to_err", bus.rsp_err, 2'b10);
    chk("to_rdata", bus.rsp_rdata, 0);
    chk("to_psel", bus.psel, 0);
    chk("to_penable", bus.penable, 0);
    step();

    // pready on the limit cycle completes normally
    issue(1'b1, 32'h28, 64'h55, 8'h01);
    run_wait(5, 32'h0, lat);
    chk("lim_lat", 64'(lat), 6);
    chk("lim_err", bus.rsp_err, 0);
    chk("lim_rdata", bus.rsp_rdata, 0);
    step();

    // response backpressure
    bus.rsp_ready = 1'b0;
    bus.prdata = 64'h0000_0000_CAFE_F00D;
    issue(1'b0, 32'h30, 64'h0, 8'h00);
    run_wait(2, 32'h0, lat);
    chk("bp_lat", 64'(lat), 3);
    chk("bp_rdata", bus.rsp_rdata, 64'hCAFE_F00D);
    bus.prdata    = '0;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 32'h40;
    bus.cmd_wdata = 64'h77;
    bus.cmd_strb  = 8'h03;
    bad = 1'b0;
    repeat (5) begin
      step();
      if (!(bus.rsp_valid && bus.rsp_rdata == 64'hCAFE_F00D &&
            bus.rsp_err == 2'b00 && !bus.cmd_ready && !bus.psel))
        bad = 1'b1;
    end
    chk("bp_stall", bad, 0);
    bus.rsp_ready = 1'b1;
    step();
    chk("bp_ready_after", bus.cmd_ready, 1);
    chk("bp_no_setup", bus.psel, 0);
    step();
    bus.cmd_valid = 1'b0;
    chk("bp_next_psel", bus.psel, 1);
    chk("bp_next_paddr", bus.paddr, 64'h40);
    run_wait(2, 32'h0, lat);
    chk("bp_next_lat", 64'(lat), 3);
    step();

    // async reset mid-ACCESS
    issue(1'b1, 32'h50, 64'h99, 8'hFF);
    step();
    chk("ar_penable", bus.penable, 1);
    #2 presetn = 1'b0;
    #1;
    chk("ar_psel", bus.psel, 0);
    chk("ar_pen0", bus.penable, 0);
    chk("ar_rvalid", bus.rsp_valid, 0);
    #2 presetn = 1'b1;
    step();
    chk("ar_cmd_ready", bus.cmd_ready, 1);
    chk("ar_idle_psel", bus.psel, 0);
    issue(1'b1, 32'h58, 64'h1234, 8'hFF);
    chk("ar_pwdata", bus.pwdata, 64'h1234);
    run_wait(2, 32'h0, lat);
    chk("ar_lat", 64'(lat), 3);
    chk("ar_err", bus.rsp_err, 0);
    step();

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule

// File: doc/apb_master.md
# apb_master

APB4 requester that turns a simple valid/ready command stream into single APB transfers toward the memory slave, and returns read data and error status on a valid/ready response stream. It sits between the system-side initiator logic and the APB memory's bus port. A wait-state watchdog keeps a stalled slave from hanging the command path.

## Interface
- ADDR_W, 32, APB address width
- DATA_W, 64, APB data width; must be a multiple of 8
- TIMEOUT_CYC, 256, max ACCESS-phase cycles with pready low before abort; must be ≥1
- pclk  in  1  bus clock; all logic on rising edge
- presetn  in  1  reset; asynchronous, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when both high
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  byte address, passed through unchecked
- cmd_wdata  in  DATA_W  write data
- cmd_strb  in  DATA_W/8  write byte strobes
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when both high
- rsp_rdata  out  DATA_W  read data; 0 for writes and aborted transfers
- rsp_err  out  2  [0] slave error (pslverr), [1] timeout abort
- psel, penable, pwrite  out  1  APB control
- paddr  out  ADDR_W; pwdata  out  DATA_W; pstrb  out  DATA_W/8
- prdata  in  DATA_W; pready  in  1; pslverr  in  1

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE: cmd_ready=1. On handshake, register write, addr, wdata, and strb onto pwrite, paddr, pwdata, and pstrb. pstrb=0 for reads. Go to SETUP.
- SETUP: psel=1, penable=0. Unconditionally go to ACCESS.
- ACCESS: psel=1, penable=1. The wait counter increments each cycle with pready=0.
  - pready=1: capture prdata (reads only; writes capture 0) and capture pslverr into rsp_err[0]. Go to RESP.
  - pready=0 and the counter reaches TIMEOUT_CYC-1: abort. Set rsp_err=2'b10 and rsp_rdata=0. Go to RESP.
  - If pready rises on the same cycle the limit is reached, it counts as a normal completion, not a timeout.
- RESP: psel=0, penable=0, rsp_valid=1. rsp_rdata and rsp_err stay stable until rsp_ready. On handshake, go to IDLE.
- The wait counter clears on entry to SETUP. It is wide enough for TIMEOUT_CYC; $clog2(TIMEOUT_CYC+1) bits.
- pslverr is sampled only on the completion cycle and ignored otherwise. prdata is sampled only on read completion.
- paddr, pwrite, pwdata, and pstrb hold their values from SETUP through the end of the transfer. After that, they keep their last value until the next accept.
- One outstanding transfer at a time. cmd_ready is low in SETUP, ACCESS, and RESP.

## Timing
- Reset (presetn low, async): state=IDLE. All outputs are 0 except cmd_ready, which is 1 once out of reset (cmd_ready is a decode of IDLE). Counter cleared.
- Reset asserted mid-transfer: psel and penable drop immediately; the pending response is discarded.
- All APB and response outputs are registered. cmd_ready is decoded from state.
- Zero-wait transfer, with the accept edge at cycle T:
  - SETUP at T+1.
  - ACCESS with pready at T+2.
  - rsp_valid at T+3.
  - Next accept possible at T+4 if rsp_ready was high at T+3.
- Each pready-low cycle adds one cycle of latency.
- Timeout: rsp_valid is asserted TIMEOUT_CYC cycles after ACCESS entry.
- An rsp_ready stall holds RESP indefinitely; the APB bus stays idle (psel=0) meanwhile.

## Structure
- Shared package apb_pkg:
  - state enum apb_mst_state_e
  - rsp_err bit indices (RSP_ERR_SLV=0, RSP_ERR_TMO=1)
  - the DATA_W/8 strobe-width helper
- Sub-module apb_wdog: the wait-state counter.
  - Inputs: clr and tick.
  - Output: expired at TIMEOUT_CYC-1.
  - Same pclk/presetn.

## Test plan
- Zero-wait write: addr 0x10, wdata 0xDEAD_BEEF_0123_4567, strb 0xFF, slave pready=1 → psel at T+1, penable at T+2, rsp_valid at T+3 with rsp_err=0, rsp_rdata=0.
- Read with 3 wait states: addr 0x08, prdata 0x1122_3344_5566_7788 → rsp_valid at T+6, rsp_rdata=0x1122_3344_5566_7788, pstrb=0 throughout.
- Slave error: read to 0x0001_0000 with pslverr=1 at completion → rsp_err=2'b01, rsp_rdata=0x1122_3344_5566_7788 as returned on prdata. pslverr pulses outside completion are ignored.
- Timeout: TIMEOUT_CYC=4, pready held 0 → psel drops and rsp_valid=1 with rsp_err=2'b10 exactly 4 cycles after ACCESS entry. With pready rising on that 4th cycle instead, rsp_err=0.
- Backpressure: rsp_ready=0 for 5 cycles → rsp outputs stable, cmd_ready=0, no new SETUP. After rsp_ready, the next command is accepted the following cycle.
- Async reset asserted mid-ACCESS → psel, penable, and rsp_valid go 0 without a clock edge. After release, cmd_ready=1 and a fresh write completes normally.
